// File: rtl/dot_product_seq_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding and
// the minimum accumulator width rule.
package dot_product_seq_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    // Smallest accumulator that can hold len products of two n-bit operands.
    function automatic int min_acc_width(input int n, input int len);
        return 2 * n + $clog2(len);
    endfunction

endpackage

// File: rtl/dot_product_seq.sv
// Sequencer around a start/ready shift-add multiplier: takes LEN operand pairs,
// runs one multiply per pair, accumulates the products and emits the dot product.
module dot_product_seq
    import dot_product_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             mul_start,
    output logic [N-1:0]     mul_multiplier,
    output logic [N-1:0]     mul_multiplicand,
    input  logic             mul_ready,
    input  logic [2*N-1:0]   mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam int CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    generate
        if (LEN < 2 || ACC_W < min_acc_width(N, LEN)) begin : g_bad_params
            $error("dot_product_seq: LEN must be >= 2 and ACC_W >= 2*N + clog2(LEN)");
        end
    endgenerate

    logic [1:0]       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [N-1:0]     a_reg, a_next;
    logic [N-1:0]     b_reg, b_next;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = in_a;
                    b_next     = in_b;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                // mul_ready is only meaningful here; in other states it is ignored.
                if (mul_ready) begin
                    acc_next = acc_reg + ACC_W'(mul_product);
                    if (count_reg == LAST) begin
                        state_next = OUT;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                        state_next = IDLE;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_next   = '0;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    // Every output is a decode of registered state, so none can glitch.
    assign in_ready         = (state_reg == IDLE);
    assign mul_start        = (state_reg == START);
    assign out_valid        = (state_reg == OUT);
    assign mul_multiplier   = a_reg;
    assign mul_multiplicand = b_reg;
    assign out_sum          = acc_reg;

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed testbench for dot_product_seq paired with a cycle-accurate N=4
// shift-add multiplier model (start sampled at E1, ready pulse after E(N+1)).
module tb_dot_product_seq;

    localparam int N     = 4;
    localparam int LEN   = 4;
    localparam int ACC_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             mul_start;
    logic [N-1:0]     mul_multiplier;
    logic [N-1:0]     mul_multiplicand;
    logic             mul_ready;
    logic [2*N-1:0]   mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             spur;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts = 0;

    always #5 clk = ~clk;

    dot_product_seq #(.N(N), .LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_ready        (mul_ready),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sum          (out_sum)
    );

    // Shift-add multiplier model: one partial-product step per cycle after start.
    logic           m_busy;
    logic           m_ready;
    logic [1:0]     m_step;
    logic [N-1:0]   m_mplier;
    logic [2*N-1:0] m_mcand;
    logic [2*N-1:0] m_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_ready  <= 1'b0;
            m_step   <= '0;
            m_mplier <= '0;
            m_mcand  <= '0;
            m_acc    <= '0;
        end else begin
            m_ready <= 1'b0;
            if (mul_start && !m_busy) begin
                m_busy   <= 1'b1;
                m_step   <= '0;
                m_mplier <= mul_multiplier;
                m_mcand  <= {{N{1'b0}}, mul_multiplicand};
                m_acc    <= '0;
            end else if (m_busy) begin
                if (m_mplier[m_step]) m_acc <= m_acc + (m_mcand << m_step);
                if (m_step == 2'd3) begin
                    m_busy  <= 1'b0;
                    m_ready <= 1'b1;
                end
                m_step <= m_step + 2'd1;
            end
        end
    end

    assign mul_product = m_acc;
    assign mul_ready   = m_ready | spur;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_start) starts <= starts + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached got=running want=finished");
        $fatal(1, "watchdog");
    end

    // Present one pair (after gap idle cycles) and return the cycle index of its accept edge.
    task automatic drive_pair(input logic [N-1:0] a, input logic [N-1:0] b,
                              input int gap, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = -1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 100 && !got; i++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                got = 1'b1;
                acc_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=no_accept want=accept a=%0d b=%0d", a, b);
        end
    endtask

    task automatic send_vec(input logic [4*N-1:0] av, input logic [4*N-1:0] bv,
                            input logic [15:0] gv, output int first_cyc);
        int c;
        first_cyc = -1;
        for (int i = 0; i < LEN; i++) begin
            drive_pair(av[i*N +: N], bv[i*N +: N], int'(gv[i*4 +: 4]), c);
            if (i == 0) first_cyc = c;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int rise_cyc);
        bit got;
        got = 1'b0;
        rise_cyc = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1;
                rise_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout got=0 want=1");
        end
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (in_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got=in_ready=0 want=1");
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        // power-on reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL por_in_ready got=%0b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL por_out_valid got=%0b want=0", out_valid); end
        total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL por_mul_start got=%0b want=0", mul_start); end
        total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL por_out_sum got=%0d want=0", out_sum); end
        rst = 1'b0;
        @(negedge clk);
        // mid-stream reset, three cycles, right after an accept (state START)
        drive_pair(4'd7, 4'd9, 0, c);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready cyc%0d got=%0b want=1", i, in_ready); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid cyc%0d got=%0b want=0", i, out_valid); end
            total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL rst_mul_start cyc%0d got=%0b want=0", i, mul_start); end
            total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL rst_out_sum cyc%0d got=%0d want=0", i, out_sum); end
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%0b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%0b want=0", out_valid); end
        total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL post_rst_mul_start got=%0b want=0", mul_start); end
        total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL post_rst_out_sum got=%0d want=0", out_sum); end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int first, rise, s0;
        s0 = starts;
        send_vec({4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5}, 16'h0000, first);
        wait_out(rise);
        total++; if (out_sum !== 10'd70) begin bad++; $display("FAIL basic_sum got=%0d want=70", out_sum); end
        total++; if (rise - first != 27) begin bad++; $display("FAIL basic_latency got=%0d want=27", rise - first); end
        total++; if (starts - s0 != 4) begin bad++; $display("FAIL basic_start_pulses got=%0d want=4", starts - s0); end
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_after got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_after got=%0b want=1", in_ready); end
        $display("test_basic: sum=%0d latency=%0d starts=%0d", out_sum, rise - first, starts - s0);
    endtask

    task automatic test_max_then_clear();
        int first, rise;
        send_vec({4'd15, 4'd15, 4'd15, 4'd15}, {4'd15, 4'd15, 4'd15, 4'd15}, 16'h0000, first);
        wait_out(rise);
        total++; if (out_sum !== 10'd900) begin bad++; $display("FAIL max_sum got=%0d want=900", out_sum); end
        consume();
        send_vec({4'd1, 4'd1, 4'd1, 4'd1}, {4'd1, 4'd1, 4'd1, 4'd1}, 16'h0000, first);
        wait_out(rise);
        total++; if (out_sum !== 10'd4) begin bad++; $display("FAIL clear_sum got=%0d want=4", out_sum); end
        consume();
        $display("test_max_then_clear: last sum=4 expected");
    endtask

    task automatic test_backpressure();
        int first, rise;
        send_vec({4'd5, 4'd4, 4'd3, 4'd2}, {4'd9, 4'd8, 4'd7, 4'd6}, 16'h0000, first);
        wait_out(rise);
        total++; if (out_sum !== 10'd110) begin bad++; $display("FAIL bp_sum got=%0d want=110", out_sum); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc%0d got=%0b want=1", i, out_valid); end
            total++; if (out_sum !== 10'd110) begin bad++; $display("FAIL bp_hold_sum cyc%0d got=%0d want=110", i, out_sum); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready cyc%0d got=%0b want=0", i, in_ready); end
        end
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%0b want=1", in_ready); end
        $display("test_backpressure: held 6 cycles then one transfer");
    endtask

    task automatic test_gaps_spurious();
        int c, rise;
        in_valid = 1'b0;
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        drive_pair(4'd1, 4'd5, 3, c);
        in_valid = 1'b0;
        @(negedge clk);
        wait_idle();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        drive_pair(4'd2, 4'd6, 0, c);
        drive_pair(4'd3, 4'd7, 5, c);
        drive_pair(4'd4, 4'd8, 2, c);
        in_valid = 1'b0;
        wait_out(rise);
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL spur_out_valid got=%0b want=1", out_valid); end
        total++; if (out_sum !== 10'd70) begin bad++; $display("FAIL spur_sum got=%0d want=70", out_sum); end
        consume();
        $display("test_gaps_spurious: sum=70 expected");
    endtask

    task automatic test_reset_in_wait();
        int c, first, rise;
        bit seen;
        drive_pair(4'd1, 4'd5, 0, c);
        drive_pair(4'd2, 4'd6, 0, c);
        drive_pair(4'd3, 4'd7, 0, c);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrst_out_valid got=%0b want=0", out_valid); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL wrst_no_output got=%0b want=0", seen); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wrst_in_ready got=%0b want=1", in_ready); end
        send_vec({4'd2, 4'd2, 4'd2, 4'd2}, {4'd3, 4'd3, 4'd3, 4'd3}, 16'h0000, first);
        wait_out(rise);
        total++; if (out_sum !== 10'd24) begin bad++; $display("FAIL wrst_fresh_sum got=%0d want=24", out_sum); end
        consume();
        $display("test_reset_in_wait: fresh sum=24 expected");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        spur      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max_then_clear();
        test_backpressure();
        test_gaps_spurious();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
